// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_LVL = 1'b1;

  // Bit-counter width: max(1, clog2(n)).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_cnt.sv
// Loadable down-counter that saturates at zero; clear beats load beats decrement.
module piso_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (ld)          cnt <= ld_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: loads an N-bit word and shifts it out one
// bit per cycle, allowing a new load on the last-bit cycle for gapless streams.
module piso_tx
  import piso_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic         rdy,
  output logic         sout,
  output logic         sval,
  output logic         done
);

  localparam int CW = cnt_w(N);

  state_t        state, state_nxt;
  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          zero;
  logic          last;
  logic          can_load;
  logic          load;
  logic          head;

  assign last     = (state == SHIFT) && (cnt == '0);
  assign can_load = (state == IDLE) || last;
  assign load     = en && can_load && !pst;
  assign head     = (MSB_FIRST != 0) ? sr[N-1] : sr[0];

  piso_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (pst),
    .ld     (load),
    .dec    ((state == SHIFT) && !zero),
    .ld_val (CW'(N - 1)),
    .cnt    (cnt),
    .zero   (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (pst) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (load) state_nxt = SHIFT;
        SHIFT:   if (last) state_nxt = load ? SHIFT : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, so en and d never reach a pin
  // combinationally.
  always_comb begin
    rdy  = 1'b1;
    sval = 1'b0;
    sout = IDLE_LVL;
    done = 1'b0;
    if (state == SHIFT) begin
      rdy  = last;
      sval = 1'b1;
      sout = head;
      done = last;
    end
  end

  // Zero fill on shift is harmless: the vacated bits are never presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 sr <= '0;
    else if (pst)             sr <= '1;
    else if (load)            sr <= d;
    else if (state == SHIFT)  sr <= (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first N=8, LSB-first N=8 and N=1 builds.
module tb_piso_tx;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       pst;
  logic       en8, enl, en1;
  logic [7:0] d8, dl;
  logic [0:0] d1;
  logic       rdy8, sout8, sval8, done8;
  logic       rdyl, soutl, svall, donel;
  logic       rdy1, sout1, sval1, done1;

  exp_t q8[$];
  exp_t ql[$];
  exp_t q1[$];

  int compared   = 0;
  int mismatched = 0;

  piso_tx #(.N(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .pst(pst), .en(en8), .d(d8),
    .rdy(rdy8), .sout(sout8), .sval(sval8), .done(done8)
  );

  piso_tx #(.N(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .pst(pst), .en(enl), .d(dl),
    .rdy(rdyl), .sout(soutl), .sval(svall), .done(donel)
  );

  piso_tx #(.N(1), .MSB_FIRST(1)) u_one (
    .clk(clk), .rst(rst), .pst(pst), .en(en1), .d(d1),
    .rdy(rdy1), .sout(sout1), .sval(sval1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitors: every valid bit must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (sval8) begin
      compared++;
      if (q8.size() == 0) begin
        mismatched++;
        $display("FAIL msb_extra_bit: got sout=%0b done=%0b, required no valid bit", sout8, done8);
      end else begin
        e = q8.pop_front();
        if (sout8 !== e.b || done8 !== e.last || rdy8 !== e.last) begin
          mismatched++;
          $display("FAIL msb_bit: got sout=%0b done=%0b rdy=%0b, required %0b/%0b/%0b",
                   sout8, done8, rdy8, e.b, e.last, e.last);
        end
      end
    end
    if (svall) begin
      compared++;
      if (ql.size() == 0) begin
        mismatched++;
        $display("FAIL lsb_extra_bit: got sout=%0b done=%0b, required no valid bit", soutl, donel);
      end else begin
        e = ql.pop_front();
        if (soutl !== e.b || donel !== e.last || rdyl !== e.last) begin
          mismatched++;
          $display("FAIL lsb_bit: got sout=%0b done=%0b rdy=%0b, required %0b/%0b/%0b",
                   soutl, donel, rdyl, e.b, e.last, e.last);
        end
      end
    end
    if (sval1) begin
      compared++;
      if (q1.size() == 0) begin
        mismatched++;
        $display("FAIL n1_extra_bit: got sout=%0b done=%0b, required no valid bit", sout1, done1);
      end else begin
        e = q1.pop_front();
        if (sout1 !== e.b || done1 !== e.last || rdy1 !== e.last) begin
          mismatched++;
          $display("FAIL n1_bit: got sout=%0b done=%0b rdy=%0b, required %0b/%0b/%0b",
                   sout1, done1, rdy1, e.b, e.last, e.last);
        end
      end
    end
  end

  task automatic push8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q8.push_back('{b: w[i], last: (i == 0)});
  endtask

  task automatic expect_idle8(input string name);
    compared++;
    if ({rdy8, sout8, sval8, done8} !== 4'b1100 || q8.size() != 0) begin
      mismatched++;
      $display("FAIL %s: got rdy/sout/sval/done=%b pending=%0d, required 1100 pending=0",
               name, {rdy8, sout8, sval8, done8}, q8.size());
    end
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if ({rdy8, sout8, sval8, done8, rdyl, soutl, svall, donel, rdy1, sout1, sval1, done1}
        !== 12'b1100_1100_1100) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b, required 110011001100",
               {rdy8, sout8, sval8, done8, rdyl, soutl, svall, donel, rdy1, sout1, sval1, done1});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    en8 = 1'b1; d8 = 8'hA5; push8(8'hA5);
    @(negedge clk);
    en8 = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    expect_idle8("basic_idle_after");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    en8 = 1'b1; d8 = 8'hF0; push8(8'hF0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en8 = 1'b0;
      if (i == 7) begin
        en8 = 1'b1; d8 = 8'h0F; push8(8'h0F);
      end
      compared++;
      if (sval8 !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_contiguous: cycle %0d got sval=%0b, required 1", i, sval8);
      end
    end
    en8 = 1'b0;
    @(negedge clk);
    expect_idle8("b2b_idle_after");
  endtask

  task automatic test_preset();
    @(negedge clk);
    en8 = 1'b1; d8 = 8'h3C;
    q8.push_back('{b: 1'b0, last: 1'b0});
    q8.push_back('{b: 1'b0, last: 1'b0});
    q8.push_back('{b: 1'b1, last: 1'b0});
    @(negedge clk);
    en8 = 1'b0;
    repeat (2) @(negedge clk);
    pst = 1'b1;
    @(negedge clk);
    pst = 1'b0;
    expect_idle8("preset_abort");
    pst = 1'b1; en8 = 1'b1; d8 = 8'hFF;
    @(negedge clk);
    pst = 1'b0; en8 = 1'b0;
    expect_idle8("preset_with_en");
    en8 = 1'b1; d8 = 8'h81; push8(8'h81);
    @(negedge clk);
    en8 = 1'b0;
    repeat (8) @(negedge clk);
    expect_idle8("preset_reload_idle");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    en8 = 1'b1; d8 = 8'h5A; push8(8'h5A);
    @(negedge clk);
    en8 = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0; en8 = 1'b1; d8 = 8'hFF;
    q8.delete();
    #1;
    expect_idle8("async_reset_immediate");
    repeat (2) @(negedge clk);
    expect_idle8("reset_ignores_en");
    rst = 1'b1; d8 = 8'hC3; push8(8'hC3);
    @(negedge clk);
    en8 = 1'b0;
    repeat (8) @(negedge clk);
    expect_idle8("first_load_after_reset");
  endtask

  task automatic test_lsb_ignored();
    @(negedge clk);
    enl = 1'b1; dl = 8'h01;
    for (int i = 0; i < 8; i++) ql.push_back('{b: (i == 0), last: (i == 7)});
    @(negedge clk);
    enl = 1'b0;
    repeat (2) @(negedge clk);
    enl = 1'b1; dl = 8'hFF;
    @(negedge clk);
    enl = 1'b0;
    repeat (6) @(negedge clk);
    compared++;
    if ({rdyl, soutl, svall, donel} !== 4'b1100 || ql.size() != 0) begin
      mismatched++;
      $display("FAIL lsb_idle_after: got %b pending=%0d, required 1100 pending=0",
               {rdyl, soutl, svall, donel}, ql.size());
    end
  endtask

  task automatic test_n1();
    @(negedge clk);
    en1 = 1'b1; d1 = 1'b1;
    q1.push_back('{b: 1'b1, last: 1'b1});
    @(negedge clk);
    d1 = 1'b0;
    q1.push_back('{b: 1'b0, last: 1'b1});
    @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    compared++;
    if ({rdy1, sout1, sval1, done1} !== 4'b1100 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL n1_idle_after: got %b pending=%0d, required 1100 pending=0",
               {rdy1, sout1, sval1, done1}, q1.size());
    end
  endtask

  initial begin
    rst = 1'b0; pst = 1'b0;
    en8 = 1'b0; enl = 1'b0; en1 = 1'b0;
    d8 = '0; dl = '0; d1 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_preset();
    test_async_reset();
    test_lsb_ignored();
    test_n1();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter N, default 8: parallel word width, legal range 1..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = LSB first.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port pst, input, 1: synchronous preset, active-high.
REQ-006 SHALL have port en, input, 1: load request; qualifies d.
REQ-007 SHALL have port d, input, N: parallel word to transmit.
REQ-008 SHALL have port rdy, output, 1: block accepts a load this cycle.
REQ-009 SHALL have port sout, output, 1: serial data bit.
REQ-010 SHALL have port sval, output, 1: sout carries a valid data bit.
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking the last bit of a word.

Function
REQ-012 SHALL implement the FSM states IDLE and SHIFT; the state SHALL be registered.
REQ-013 In IDLE: rdy=1, sval=0, sout=1, done=0.
REQ-014 A load SHALL occur on any rising edge where en=1, rdy=1 and pst=0.
- A load captures d into the N-bit shift register.
- A load sets the bit counter to N-1.
- A load moves the FSM to SHIFT.
REQ-015 Latency: for a load at edge k, data bit i SHALL appear on sout with sval=1 during the cycle after edge k+i, for i=0..N-1.
- Bit order: MSB first when MSB_FIRST=1, otherwise LSB first.
REQ-016 In SHIFT: each edge SHALL shift the register by one position and decrement the counter.
REQ-017 done SHALL be 1 exactly in the cycle where the counter is 0 and the last bit is on sout.
REQ-018 rdy SHALL be 0 in SHIFT, except during the done cycle, when rdy=1.
REQ-019 A load during the done cycle SHALL start the next word with no idle gap: the first bit follows the last bit in the next cycle. Otherwise the FSM returns to IDLE.
REQ-020 An en=1 with rdy=0 SHALL be ignored.
- d is not sampled.
- No state changes.
REQ-021 pst=1 at an edge SHALL have priority over en and over shifting.
- FSM goes to IDLE.
- Shift register is set to all ones.
- Counter is cleared.
- A word in flight is aborted without a done pulse.
REQ-022 pst=1 and en=1 on the same edge SHALL result in IDLE; no load occurs.
REQ-023 N=1 SHALL give one-cycle words: done=1 and rdy=1 in every SHIFT cycle.
REQ-024 d SHALL only be sampled at load; changes to d during SHIFT SHALL NOT affect the serial output.
REQ-025 The counter width SHALL be max(1, clog2(N)) bits; the counter SHALL never wrap below 0.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for a clock edge, force all of the following:
- FSM to IDLE.
- Shift register to all zeros.
- Counter to 0.
- Outputs to sout=1, sval=0, done=0, rdy=1.
REQ-027 Reset asserted mid-word SHALL abort the word; no done pulse is produced.
REQ-028 After rst returns high, the first load SHALL be accepted on the first rising edge.

Structure
REQ-029 A shared package piso_pkg SHALL hold:
- the state encodings IDLE=1'b0, SHIFT=1'b1;
- the constant for the idle line level (1).
REQ-030 The down-counter SHALL be a sub-module piso_cnt with ports clk, rst, clr, ld, dec, ld_val, cnt, zero. The shift register and FSM SHALL stay in piso_tx.
REQ-031 All outputs SHALL be driven from registers or from state only; there SHALL be no combinational path from en or d to any output.

Verification (N=8, MSB_FIRST=1 unless stated)
REQ-032 Basic word: load d=8'hA5 → sout sequence 1,0,1,0,0,1,0,1 with sval=1 for 8 cycles; done on the 8th; rdy returns to 1.
REQ-033 Back-to-back: load 8'hF0, then en=1 with d=8'h0F during the done cycle → 16 contiguous valid bits 11110000 00001111 and two done pulses.
REQ-034 Preset mid-word: load 8'h3C, pst=1 after 3 bits → IDLE next cycle; sout=1, sval=0, no done; a new load of 8'h81 then transmits correctly.
REQ-035 Async reset: rst=0 between edges during SHIFT → outputs take reset values before the next edge; en=1 ignored while rst=0.
REQ-036 Ignored load and LSB-first: with MSB_FIRST=0, load 8'h01, pulse en with d=8'hFF mid-word → serial output 1,0,0,0,0,0,0,0 only.
REQ-037 N=1 build: load 1, then 0 on consecutive done cycles → sout 1 then 0; sval and done high both cycles.
